write_burst: RTL
================

WRITE_BURST -- requirements
Module: write_burst

Interface
REQ-001 Parameter BEATS, 6, number of 128-bit beats per burst; the block SHALL support only the value 6.
REQ-002 Parameter ADDR_STEP, 8, address increment between beats.
REQ-003 Parameter WRITE_CMD, 3'b000, command code driven during writes.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 write  in  1  one-cycle request; sampled only when busy=0.
REQ-007 address_in  in  31  start address, captured with write.
REQ-008 write_data_in  in  768  burst payload, captured with write.
REQ-009 busy  out  1  high from the cycle after an accepted write until done.
REQ-010 done  out  1  one-cycle pulse when the last command is accepted.
REQ-011 write_data_out  out  128  current beat data.
REQ-012 write_data_enable  out  1  beat data valid toward the memory write FIFO.
REQ-013 write_data_end  out  1  equals write_data_enable; each beat is a complete transfer.
REQ-014 write_data_ready  in  1  memory write FIFO accepts the beat this cycle.
REQ-015 write_address_enable  out  1  command valid toward the memory controller.
REQ-016 write_command  out  3  WRITE_CMD while write_address_enable=1, else 3'b000.
REQ-017 address_out  out  31  current beat address.
REQ-018 command_ready  in  1  controller accepts the command this cycle.

Function
REQ-019 States SHALL be IDLE, DATA, CMD and DONE.
REQ-020 IDLE: write=1 SHALL register address_in and write_data_in, clear the beat counter to 0, and move to DATA.
REQ-021 DATA: write_data_enable=1 and write_data_out=payload[128k+127:128k] for beat k; write_data_ready=1 moves the block to CMD, otherwise it holds.
REQ-022 CMD: write_address_enable=1 and address_out=start+k*ADDR_STEP (mod 2^31); command_ready=1 with k<5 increments k and moves to DATA, and with k=5 moves to DONE; otherwise it holds.
REQ-023 DONE: done=1 for exactly one cycle, then IDLE; busy=0 in DONE.
REQ-024 Data and command SHALL never both be asserted in the same cycle; each beat's data precedes its command.
REQ-025 Outputs SHALL be registered; minimum burst latency is 12 cycles from write to the done pulse with ready held high.
REQ-026 write while busy=1 SHALL be ignored; payload and address SHALL not change mid-burst.
REQ-027 Address arithmetic SHALL wrap modulo 2^31 with no carry out.
REQ-028 Ready inputs asserted outside their matching state SHALL be ignored.

Reset
REQ-029 reset=0 at a clock edge SHALL force IDLE, k=0, and all outputs to 0, including mid-burst; the aborted burst SHALL not resume.
REQ-030 The block SHALL accept a new write on the first edge after reset returns to 1.

Structure
REQ-031 The shared package SHALL hold the memory command codes (WRITE_CMD, READ_CMD), BEATS, ADDR_STEP, the 768/128 widths, and the state encoding.
REQ-032 The block SHALL be a single module with no sub-module; the beat mux SHALL be an indexed part-select.

Verification
REQ-033 Address 31'd1, payload beats 0..5 = 128'h0..5, both readies held at 1 -> six data/command pairs at addresses 1, 9, 17, 25, 33, 41, done in cycle 12.
REQ-034 write_data_ready low for 3 cycles on beat 2 -> beat 2 data is held stable and no command is issued until data is accepted.
REQ-035 Address 31'h7FFFFFF8 -> beat addresses wrap to 0, 8, 16, 24, 32 after the first.
REQ-036 Second write pulsed in DATA of beat 3 -> ignored; only one done pulse.
REQ-037 reset=0 during CMD of beat 4 -> all outputs 0 next cycle; a following write restarts at beat 0 with the new address.
REQ-038 Back-to-back bursts (write in cycle after done) -> second burst accepted, busy gap of one cycle.

Source files
------------

// File: rtl/write_burst_pkg.sv
// write_burst_pkg -- shared definitions for the burst write engine.
// Holds the memory command codes, burst geometry (beat count, address
// step, payload/beat/address widths) and the engine state encoding.
package write_burst_pkg;

  // Memory controller command codes
  localparam logic [2:0] MEM_WRITE_CMD = 3'b000;
  localparam logic [2:0] MEM_READ_CMD  = 3'b001;
  localparam int         CMD_W         = 3;

  // Burst geometry
  localparam int BURST_BEATS     = 6;
  localparam int BURST_ADDR_STEP = 8;
  localparam int BEAT_W          = 128;
  localparam int DATA_W          = BURST_BEATS * BEAT_W;  // 768
  localparam int ADDR_W          = 31;
  localparam int BEAT_CNT_W      = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_CMD  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/write_burst.sv
// write_burst -- splits one 768-bit write request into six 128-bit
// data/command pairs toward a memory controller.
//
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   write                 one-cycle request, sampled while busy=0
//   address_in            31-bit start address, captured with write
//   write_data_in         768-bit payload, captured with write
//   busy                  burst in flight (DATA/CMD states)
//   done                  one-cycle pulse after the last command is taken
//   write_data_out        current 128-bit beat
//   write_data_enable     beat valid toward the write-data FIFO
//   write_data_end        mirrors write_data_enable (single-beat transfers)
//   write_data_ready      FIFO accepts the beat
//   write_address_enable  command valid toward the controller
//   write_command         WRITE_CMD while a command is valid, else 0
//   address_out           current beat address
//   command_ready         controller accepts the command
//
// Every output is a flop; each transition loads the outputs that belong to
// the state being entered, so data and command are never valid together.
module write_burst
  import write_burst_pkg::*;
#(
  parameter int         BEATS     = BURST_BEATS,    // only 6 is supported
  parameter int         ADDR_STEP = BURST_ADDR_STEP,
  parameter logic [2:0] WRITE_CMD = MEM_WRITE_CMD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write,
  input  logic [ADDR_W-1:0] address_in,
  input  logic [DATA_W-1:0] write_data_in,
  output logic              busy,
  output logic              done,
  output logic [BEAT_W-1:0] write_data_out,
  output logic              write_data_enable,
  output logic              write_data_end,
  input  logic              write_data_ready,
  output logic              write_address_enable,
  output logic [CMD_W-1:0]  write_command,
  output logic [ADDR_W-1:0] address_out,
  input  logic              command_ready
);

  localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(BEATS - 1);
  localparam logic [ADDR_W-1:0]     STEP      = ADDR_W'(ADDR_STEP);

  state_t                state;
  logic [BEAT_CNT_W-1:0] beat;
  logic [BEAT_CNT_W-1:0] beat_nxt;
  logic [ADDR_W-1:0]     addr_q;    // address of the current beat
  logic [DATA_W-1:0]     payload_q;

  assign beat_nxt = beat + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state                <= ST_IDLE;
      beat                 <= '0;
      addr_q               <= '0;
      payload_q            <= '0;
      busy                 <= 1'b0;
      done                 <= 1'b0;
      write_data_out       <= '0;
      write_data_enable    <= 1'b0;
      write_data_end       <= 1'b0;
      write_address_enable <= 1'b0;
      write_command        <= 3'b000;
      address_out          <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        // DONE already shows busy=0, so a request there is legal and
        // yields back-to-back bursts with a single idle busy cycle.
        ST_IDLE, ST_DONE: begin
          if (write) begin
            addr_q            <= address_in;
            payload_q         <= write_data_in;
            beat              <= '0;
            state             <= ST_DATA;
            busy              <= 1'b1;
            write_data_enable <= 1'b1;
            write_data_end    <= 1'b1;
            write_data_out    <= write_data_in[BEAT_W-1:0];
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end

        ST_DATA: begin
          if (write_data_ready) begin
            state                <= ST_CMD;
            write_data_enable    <= 1'b0;
            write_data_end       <= 1'b0;
            write_data_out       <= '0;
            write_address_enable <= 1'b1;
            write_command        <= WRITE_CMD;
            address_out          <= addr_q;
          end
        end

        ST_CMD: begin
          if (command_ready) begin
            write_address_enable <= 1'b0;
            write_command        <= 3'b000;
            address_out          <= '0;
            if (beat == LAST_BEAT) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              beat              <= beat_nxt;
              addr_q            <= addr_q + STEP;  // wraps mod 2^31
              state             <= ST_DATA;
              write_data_enable <= 1'b1;
              write_data_end    <= 1'b1;
              write_data_out    <= payload_q[beat_nxt*BEAT_W +: BEAT_W];
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
